// File: rtl/axi_rd_mem_pkg.sv
// Shared AXI read-channel definitions for the memory-backed read slave:
// response codes and the FSM state encodings.
package axi_rd_mem_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;

endpackage

// File: rtl/axi_rd_mem_array.sv
// Word storage for axi_rd_mem: one write port and one registered read port.
// A read and a write to the same word in one cycle returns the old word.
module axi_rd_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [IDX_W-1:0]      waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [IDX_W-1:0]      raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  // The read register only moves on re, so a presented beat stays put.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/axi_rd_mem.sv
// AXI4 read-only slave serving INCR bursts from an internal word memory
// with a fixed access latency, one outstanding burst, and a preload port.
module axi_rd_mem
  import axi_rd_mem_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR          = 32'h4000_0000,
  parameter int          C_S_AXI_ADDR_WIDTH = 32,
  parameter int          C_S_AXI_DATA_WIDTH = 32,
  parameter int          C_S_AXI_ID_WIDTH   = 1,
  parameter int          MEM_WORDS          = 1024,
  parameter int          RD_LATENCY         = 2
) (
  input  logic                          S_AXI_ACLK,
  input  logic                          S_AXI_ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [7:0]                    S_AXI_ARLEN,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]   S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0] S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RLAST,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic                          PRELOAD_WE,
  input  logic [$clog2(MEM_WORDS)-1:0]  PRELOAD_ADDR,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] PRELOAD_DATA
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int BYTES    = C_S_AXI_DATA_WIDTH / 8;
  localparam int OFF_BITS = $clog2(BYTES);
  localparam int IDX_W    = $clog2(MEM_WORDS);

  localparam logic [AW-1:0] BASE       = AW'(BASE_ADDR);
  localparam logic [AW-1:0] STEP       = AW'(BYTES);
  localparam logic [AW-1:0] ALIGN_MASK = ~AW'(BYTES - 1);
  localparam logic [AW:0]   SPAN       = (AW + 1)'(MEM_WORDS * BYTES);
  localparam logic [3:0]    WAIT_INIT  = 4'((RD_LATENCY > 0) ? RD_LATENCY - 1 : 0);

  logic [1:0]                  state_q, state_d;
  logic                        arready_q, arready_d;
  logic                        rvalid_q, rvalid_d;
  logic                        rlast_q, rlast_d;
  logic [1:0]                  rresp_q, rresp_d;
  logic                        okay_q, okay_d;
  logic [C_S_AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [AW-1:0]               addr_q, addr_d;
  logic [7:0]                  len_q, len_d;
  logic [7:0]                  beat_q, beat_d;
  logic [3:0]                  wait_q, wait_d;

  logic                          fetch, fetch_in_range;
  logic [AW-1:0]                 fetch_addr, fetch_off;
  logic [7:0]                    fetch_beat, fetch_len;
  logic [IDX_W-1:0]              rd_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] mem_rdata;

  // A "fetch" loads the next beat into the output registers; addr_q always
  // holds the byte address of the beat currently (or next) presented.
  always_comb begin
    state_d    = state_q;
    arready_d  = 1'b0;
    rvalid_d   = rvalid_q;
    rlast_d    = rlast_q;
    rresp_d    = rresp_q;
    okay_d     = okay_q;
    rid_d      = rid_q;
    addr_d     = addr_q;
    len_d      = len_q;
    beat_d     = beat_q;
    wait_d     = wait_q;
    fetch      = 1'b0;
    fetch_addr = addr_q;
    fetch_beat = beat_q;
    fetch_len  = len_q;

    case (state_q)
      ST_IDLE: begin
        arready_d = 1'b1;
        if (S_AXI_ARVALID && arready_q) begin
          arready_d = 1'b0;
          rid_d     = S_AXI_ARID;
          addr_d    = S_AXI_ARADDR & ALIGN_MASK;
          len_d     = S_AXI_ARLEN;
          beat_d    = 8'd0;
          wait_d    = WAIT_INIT;
          if (RD_LATENCY == 0) begin
            fetch      = 1'b1;
            fetch_addr = S_AXI_ARADDR & ALIGN_MASK;
            fetch_beat = 8'd0;
            fetch_len  = S_AXI_ARLEN;
            state_d    = ST_BURST;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (wait_q == 4'd0) begin
          fetch      = 1'b1;
          fetch_beat = 8'd0;
          state_d    = ST_BURST;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      ST_BURST: begin
        if (S_AXI_RREADY) begin
          if (rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            arready_d = 1'b1;
            state_d   = ST_IDLE;
          end else begin
            fetch      = 1'b1;
            fetch_addr = addr_q + STEP;
            fetch_beat = beat_q + 8'd1;
            addr_d     = fetch_addr;
            beat_d     = fetch_beat;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    fetch_off      = fetch_addr - BASE;
    fetch_in_range = ({1'b0, fetch_off} < SPAN);

    if (fetch) begin
      rvalid_d = 1'b1;
      rlast_d  = (fetch_beat == fetch_len);
      okay_d   = fetch_in_range;
      rresp_d  = fetch_in_range ? RESP_OKAY : RESP_DECERR;
    end
  end

  assign rd_idx = IDX_W'(fetch_off >> OFF_BITS);

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state_q   <= ST_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      okay_q    <= 1'b0;
      rid_q     <= '0;
      addr_q    <= '0;
      len_q     <= 8'd0;
      beat_q    <= 8'd0;
      wait_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
      rresp_q   <= rresp_d;
      okay_q    <= okay_d;
      rid_q     <= rid_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      beat_q    <= beat_d;
      wait_q    <= wait_d;
    end
  end

  axi_rd_mem_array #(
    .DATA_WIDTH(C_S_AXI_DATA_WIDTH),
    .DEPTH     (MEM_WORDS),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (S_AXI_ACLK),
    .we   (PRELOAD_WE),
    .waddr(PRELOAD_ADDR),
    .wdata(PRELOAD_DATA),
    .re   (fetch && fetch_in_range),
    .raddr(rd_idx),
    .rdata(mem_rdata)
  );

  // Out-of-range and post-reset beats read as zero regardless of the array.
  assign S_AXI_RDATA   = okay_q ? mem_rdata : '0;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RLAST   = rlast_q;
  assign S_AXI_RRESP   = rresp_q;
  assign S_AXI_RID     = rid_q;

endmodule

// File: tb/tb_axi_rd_mem.sv
// Bench for axi_rd_mem: two instances (latency 2 and latency 0) share one
// AR/R master and are checked every cycle against a burst-level memory model.
module tb_axi_rd_mem;

  localparam logic [31:0] BASE  = 32'h4000_0000;
  localparam int          WORDS = 1024;

  logic        clk;
  logic        reset = 1'b1;
  logic        arid = 1'b0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic        arvalid = 1'b0;
  logic        rready = 1'b0;
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = '0;
  logic [31:0] pre_data = '0;

  logic [1:0]       arready_w, rvalid_w, rlast_w, rid_w;
  logic [1:0][1:0]  rresp_w;
  logic [1:0][31:0] rdata_w;

  logic [31:0] mem_model [WORDS];
  logic [31:0] exp_data [256];
  logic [1:0]  exp_resp [256];
  logic        exp_id;
  int          exp_n;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int rmode = 0;
  bit prev_reset = 1'b1;
  bit active [2];
  bit started [2];
  bit done_chk [2];
  int ptr [2];
  int due [2];

  axi_rd_mem #(.RD_LATENCY(2)) u_dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(reset),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_w[0]),
    .S_AXI_RID(rid_w[0]), .S_AXI_RDATA(rdata_w[0]), .S_AXI_RRESP(rresp_w[0]),
    .S_AXI_RLAST(rlast_w[0]), .S_AXI_RVALID(rvalid_w[0]), .S_AXI_RREADY(rready),
    .PRELOAD_WE(pre_we), .PRELOAD_ADDR(pre_addr), .PRELOAD_DATA(pre_data)
  );

  axi_rd_mem #(.RD_LATENCY(0)) u_dut_lat0 (
    .S_AXI_ACLK(clk), .S_AXI_ARESET(reset),
    .S_AXI_ARID(arid), .S_AXI_ARADDR(araddr), .S_AXI_ARLEN(arlen),
    .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready_w[1]),
    .S_AXI_RID(rid_w[1]), .S_AXI_RDATA(rdata_w[1]), .S_AXI_RRESP(rresp_w[1]),
    .S_AXI_RLAST(rlast_w[1]), .S_AXI_RVALID(rvalid_w[1]), .S_AXI_RREADY(rready),
    .PRELOAD_WE(pre_we), .PRELOAD_ADDR(pre_addr), .PRELOAD_DATA(pre_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: time limit reached after %0d cycles", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  // rmode 0: always ready, 1: toggle every cycle, 2: random ~70% ready
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       rready = 1'b1;
        1:       rready = ~rready;
        default: rready = ($urandom_range(0, 99) < 70);
      endcase
    end
  end

  function automatic int lat_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s (cycle %0d): got 0x%0h, required 0x%0h", name, cyc, act, req);
    end
  endtask

  // Expected beats straight from the address map: INCR, 32-bit wrap, DECERR outside the window
  task automatic buildExpect(input logic id, input logic [31:0] a, input logic [7:0] len);
    exp_id = id;
    exp_n  = int'(len) + 1;
    for (int n = 0; n < exp_n; n++) begin
      logic [31:0] ba;
      ba = (a & 32'hFFFF_FFFC) + 32'(n * 4);
      if (ba >= BASE && ba < BASE + 32'(WORDS * 4)) begin
        exp_data[n] = mem_model[(ba - BASE) >> 2];
        exp_resp[n] = 2'b00;
      end else begin
        exp_data[n] = 32'h0;
        exp_resp[n] = 2'b11;
      end
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (prev_reset) begin
        checkOutput("reset outputs",
          64'({arready_w[i], rvalid_w[i], rlast_w[i], rresp_w[i], rid_w[i], rdata_w[i]}), 64'(0));
        active[i] = 1'b0;
        started[i] = 1'b0;
        done_chk[i] = 1'b0;
      end else if (active[i]) begin
        checkOutput("arready while busy", 64'(arready_w[i]), 64'(0));
        if (!started[i]) begin
          checkOutput("first beat latency", 64'(rvalid_w[i]), 64'(cyc == due[i]));
          if (cyc >= due[i]) started[i] = 1'b1;
        end
        if (started[i]) begin
          checkOutput("rvalid during burst", 64'(rvalid_w[i]), 64'(1));
          if (rvalid_w[i]) begin
            checkOutput("beat id/last/resp/data",
              64'({rid_w[i], rlast_w[i], rresp_w[i], rdata_w[i]}),
              64'({exp_id, (ptr[i] == exp_n - 1), exp_resp[ptr[i]], exp_data[ptr[i]]}));
            if (rready) begin
              ptr[i]++;
              if (ptr[i] == exp_n) begin
                active[i] = 1'b0;
                done_chk[i] = 1'b1;
              end
            end
          end
        end
      end else begin
        if (done_chk[i]) begin
          checkOutput("idle after last beat", 64'({rvalid_w[i], arready_w[i]}), 64'(2'b01));
        end else begin
          checkOutput("no beat while idle", 64'(rvalid_w[i]), 64'(0));
        end
        done_chk[i] = 1'b0;
      end
    end
    if (arvalid && !reset && (arready_w != 2'b00)) begin
      buildExpect(arid, araddr, arlen);
      for (int i = 0; i < 2; i++) begin
        if (arready_w[i]) begin
          active[i] = 1'b1;
          started[i] = 1'b0;
          ptr[i] = 0;
          due[i] = cyc + 1 + lat_of(i);
        end
      end
    end
    prev_reset = reset;
  end

  // Called and returns at posedge+1; handshake happens on the first posedge with both ready
  task automatic applyStimulus(input logic id, input logic [31:0] a, input logic [7:0] len);
    int k;
    k = 0;
    while (arready_w != 2'b11 && k < 300) begin
      @(posedge clk);
      #1;
      k++;
    end
    checkOutput("arready wait bound", 64'(arready_w), 64'(2'b11));
    arid = id;
    araddr = a;
    arlen = len;
    arvalid = 1'b1;
    @(posedge clk);
    #1;
    arvalid = 1'b0;
  endtask

  task automatic waitIdle();
    int k;
    k = 0;
    while ((active[0] || active[1]) && k < 3000) begin
      @(posedge clk);
      k++;
    end
    checkOutput("burst completion bound", 64'({active[0], active[1]}), 64'(0));
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int idx, input logic [31:0] d);
    pre_we = 1'b1;
    pre_addr = 10'(idx);
    pre_data = d;
    mem_model[idx] = d;
    @(posedge clk);
    #1;
    pre_we = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic [7:0]  len;

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkOutput("arready after reset release", 64'(arready_w), 64'(2'b11));
    @(posedge clk);
    #1;

    for (int w = 0; w < WORDS; w++) begin
      preload(w, (w < 4) ? 32'(32'h11 * (w + 1)) : $urandom);
    end

    // Basic burst, plus a same-edge preload of word 1 as the latency-2 DUT fetches it
    $display("[TB] directed: 4-beat burst, RREADY high");
    rmode = 0;
    applyStimulus(1'b0, 32'h4000_0000, 8'd3);
    checkOutput("model burst length", 64'(exp_n), 64'(4));
    for (int n = 0; n < 4; n++) begin
      checkOutput("model beat data", 64'(exp_data[n]), 64'(32'h11 * (n + 1)));
    end
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    pre_we = 1'b1;
    pre_addr = 10'd1;
    pre_data = 32'hDEAD_0022;
    mem_model[1] = 32'hDEAD_0022;
    @(negedge clk);
    checkOutput("lat2 first beat at T+3", 64'({rvalid_w[0], rdata_w[0]}), 64'({1'b1, 32'h11}));
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    waitIdle();
    preload(1, 32'h22);

    $display("[TB] directed: 4-beat burst, RREADY toggling");
    rmode = 1;
    applyStimulus(1'b0, 32'h4000_0000, 8'd3);
    waitIdle();

    $display("[TB] directed: burst crossing the top of the window");
    rmode = 0;
    applyStimulus(1'b0, 32'h4000_0FF8, 8'd3);
    checkOutput("model beat1 okay", 64'({exp_resp[1], exp_data[1]}), 64'({2'b00, mem_model[1023]}));
    checkOutput("model beat2 decerr", 64'({exp_resp[2], exp_data[2]}), 64'({2'b11, 32'h0}));
    checkOutput("model beat3 decerr", 64'({exp_resp[3], exp_data[3]}), 64'({2'b11, 32'h0}));
    waitIdle();

    $display("[TB] directed: single beat, ID 1");
    applyStimulus(1'b1, 32'h4000_0008, 8'd0);
    @(negedge clk);
    checkOutput("lat0 single beat", 64'({rvalid_w[1], rid_w[1], rlast_w[1], rdata_w[1]}),
                64'({3'b111, 32'h33}));
    @(negedge clk);
    checkOutput("lat0 idle after beat", 64'({rvalid_w[1], arready_w[1]}), 64'(2'b01));
    waitIdle();

    $display("[TB] directed: reset during beat 2 of 8");
    applyStimulus(1'b0, 32'h4000_0100, 8'd7);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    applyStimulus(1'b0, 32'h4000_0100, 8'd7);
    waitIdle();

    $display("[TB] random bursts");
    rmode = 2;
    for (int t = 0; t < 40; t++) begin
      repeat (2) preload($urandom_range(0, WORDS - 1), $urandom);
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5, 6: a = 32'h3FFF_FFE0 + 32'($urandom_range(0, 4160));
        7:                   a = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
        8:                   a = $urandom;
        default:             a = 32'h4000_0FF0 + 32'($urandom_range(0, 31));
      endcase
      len = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(0, 7));
      if (t == 5) begin
        a = BASE;
        len = 8'd255;
      end
      applyStimulus(1'($urandom_range(0, 1)), a, len);
      waitIdle();
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
